// File: rtl/park_pkg.sv
// Shared types and sensor-code tables for the parking-lot beam-sensor emulator.
package park_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PH1   = 3'd1,
        PH2   = 3'd2,
        PH3   = 3'd3,
        QUIET = 3'd4
    } state_t;

    // {Pin, Pout} codes; 1 = beam broken
    localparam logic [1:0] SENS_IDLE = 2'b00;
    localparam logic [1:0] SENS_IN   = 2'b10;
    localparam logic [1:0] SENS_BOTH = 2'b11;
    localparam logic [1:0] SENS_OUT  = 2'b01;

    // Indexed by state_t; element 0 is IDLE, element 4 is QUIET.
    localparam logic [4:0][1:0] ENTER_CODE = {SENS_IDLE, SENS_OUT, SENS_BOTH, SENS_IN, SENS_IDLE};
    localparam logic [4:0][1:0] EXIT_CODE  = {SENS_IDLE, SENS_IN, SENS_BOTH, SENS_OUT, SENS_IDLE};

    function automatic logic [1:0] phase_code(input state_t s, input logic dir);
        return dir ? ENTER_CODE[s] : EXIT_CODE[s];
    endfunction

    function automatic state_t next_phase(input state_t s);
        state_t n;
        case (s)
            PH1:     n = PH2;
            PH2:     n = PH3;
            PH3:     n = QUIET;
            default: n = IDLE;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/park_sensor_gen_phase_timer.sv
// Phase hold timer: counts 0..HOLD_CYCLES-1 while enabled, wraps on terminal count.
module phase_timer #(
    parameter  int HOLD_CYCLES = 2000000,
    localparam int TW          = $clog2(HOLD_CYCLES)
) (
    input  logic Clk,
    input  logic Reset,
    input  logic clr,
    input  logic en,
    output logic tc,
    output logic near_tc
);

    localparam logic [TW-1:0] LAST = TW'(HOLD_CYCLES - 1);
    localparam logic [TW-1:0] NEAR = TW'(HOLD_CYCLES - 2);

    logic [TW-1:0] count;

    assign tc      = en && (count == LAST);
    // One cycle ahead of tc, so a registered pulse can land on the terminal cycle.
    assign near_tc = en && (count == NEAR);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= tc ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/park_sensor_gen.sv
// Emulates car entry/exit by driving the Pin/Pout beam-sensor sequence, gated by the live car count.
module park_sensor_gen
    import park_pkg::*;
#(
    parameter int HOLD_CYCLES = 2000000,
    parameter int MAX_CARS    = 15
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       CmdValid,
    input  logic       CmdDir,
    output logic       CmdReady,
    input  logic [3:0] CarCount,
    output logic       Pin,
    output logic       Pout,
    output logic       Busy,
    output logic       SeqDone,
    output logic       Reject
);

    localparam int         TW       = $clog2(HOLD_CYCLES);
    localparam logic [3:0] LOT_FULL = 4'(MAX_CARS);

    state_t state;
    logic   dir;
    logic   tc;
    logic   near_tc;
    logic   refuse;

    assign CmdReady = (state == IDLE);
    assign Busy     = (state != IDLE);
    assign refuse   = CmdDir ? (CarCount == LOT_FULL) : (CarCount == 4'd0);

    // Held clear while idle, so every sequence starts PH1 at count zero.
    phase_timer #(.HOLD_CYCLES(HOLD_CYCLES)) u_timer (
        .Clk     (Clk),
        .Reset   (Reset),
        .clr     (state == IDLE),
        .en      (state != IDLE),
        .tc      (tc),
        .near_tc (near_tc)
    );

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state       <= IDLE;
            dir         <= 1'b0;
            {Pin, Pout} <= SENS_IDLE;
            SeqDone     <= 1'b0;
            Reject      <= 1'b0;
        end else begin
            SeqDone <= 1'b0;
            Reject  <= 1'b0;
            case (state)
                IDLE: begin
                    if (CmdValid) begin
                        if (refuse) begin
                            Reject <= 1'b1;
                        end else begin
                            dir         <= CmdDir;
                            state       <= PH1;
                            {Pin, Pout} <= phase_code(PH1, CmdDir);
                        end
                    end
                end
                QUIET: begin
                    if (near_tc) SeqDone <= 1'b1;
                    if (tc) begin
                        state       <= IDLE;
                        {Pin, Pout} <= SENS_IDLE;
                    end
                end
                default: begin
                    if (tc) begin
                        state       <= next_phase(state);
                        {Pin, Pout} <= phase_code(next_phase(state), dir);
                    end
                end
            endcase
        end
    end

    // TW is part of the block's parameter set; the timer derives the same width internally.
    if (TW < 1) begin : g_bad_hold
        $error("HOLD_CYCLES must be >= 2");
    end

endmodule

// File: tb/tb_park_sensor_gen.sv
// Self-checking bench for park_sensor_gen against a cycle-count reference model.
module tb_park_sensor_gen;

    localparam int H    = 4;
    localparam int MAXC = 15;

    logic       Clk = 1'b0;
    logic       Reset = 1'b0;
    logic       CmdValid = 1'b0;
    logic       CmdDir = 1'b0;
    logic [3:0] CarCount = 4'd0;
    logic       CmdReady, Pin, Pout, Busy, SeqDone, Reject;

    always #5 Clk = ~Clk;

    park_sensor_gen #(.HOLD_CYCLES(H), .MAX_CARS(MAXC)) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .CmdValid (CmdValid),
        .CmdDir   (CmdDir),
        .CmdReady (CmdReady),
        .CarCount (CarCount),
        .Pin      (Pin),
        .Pout     (Pout),
        .Busy     (Busy),
        .SeqDone  (SeqDone),
        .Reject   (Reject)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: t = cycles since accept (-1 when idle)
    int       t = -1;
    logic     mdir = 1'b0;
    logic     mrej = 1'b0;
    logic [1:0] enter_seq [4] = '{2'b10, 2'b11, 2'b01, 2'b00};
    logic [1:0] exit_seq  [4] = '{2'b01, 2'b11, 2'b10, 2'b00};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    endtask

    function automatic logic [5:0] model_out();
        logic [1:0] code;
        code = 2'b00;
        if (t >= 0) code = mdir ? enter_seq[t / H] : exit_seq[t / H];
        // {Pin, Pout, Busy, CmdReady, SeqDone, Reject}
        return {code, t >= 0, t < 0, t == 4 * H - 1, mrej};
    endfunction

    task automatic model_edge();
        mrej = 1'b0;
        if (t < 0) begin
            if (CmdValid) begin
                if ((CmdDir && CarCount == MAXC) || (!CmdDir && CarCount == 0)) begin
                    mrej = 1'b1;
                end else begin
                    t    = 0;
                    mdir = CmdDir;
                end
            end
        end else begin
            t++;
            if (t == 4 * H) t = -1;
        end
    endtask

    task automatic cycle(input string tag);
        @(posedge Clk);
        model_edge();
        #1;
        check(tag, {Pin, Pout, Busy, CmdReady, SeqDone, Reject}, model_out());
    endtask

    initial begin
        int dones;
        int r;
        bit found;

        repeat (2) @(negedge Clk);
        check("reset_outs", {Pin, Pout, Busy, SeqDone, Reject}, 5'b0);
        Reset = 1'b1;
        #1;
        check("ready_after_reset", CmdReady, 1'b1);

        // Directed entry, single-cycle command pulse
        CmdValid = 1'b1; CmdDir = 1'b1; CarCount = 4'd3;
        cycle("enter_accept");
        CmdValid = 1'b0;
        repeat (20) cycle("enter_seq");

        // Directed exit
        CmdValid = 1'b1; CmdDir = 1'b0;
        cycle("exit_accept");
        CmdValid = 1'b0;
        repeat (20) cycle("exit_seq");

        // Full lot and empty lot refusals
        CmdValid = 1'b1; CmdDir = 1'b1; CarCount = 4'd15;
        cycle("full_reject");
        CmdValid = 1'b0;
        repeat (3) cycle("full_after");
        CmdValid = 1'b1; CmdDir = 1'b0; CarCount = 4'd0;
        cycle("empty_reject");
        CmdValid = 1'b0;
        repeat (3) cycle("empty_after");

        // Held command: back-to-back sequences, dir toggles ignored while busy
        dones = 0;
        CmdValid = 1'b1; CarCount = 4'd5; CmdDir = 1'b1;
        for (int i = 0; i < 40; i++) begin
            cycle("held_valid");
            dones += int'(SeqDone);
            CmdDir = (t >= 0 && t < 4 * H - 1) ? 1'($urandom) : 1'b1;
        end
        check("held_seqdone_count", dones, 2);
        CmdValid = 1'b0;
        repeat (20) cycle("held_drain");

        // Randomized traffic with boundary-heavy car counts
        for (int i = 0; i < 800; i++) begin
            CmdValid = ($urandom_range(0, 3) == 0);
            CmdDir   = 1'($urandom);
            r        = $urandom_range(0, 3);
            CarCount = (r == 0) ? 4'd0 : (r == 1) ? 4'd15 : 4'($urandom_range(0, 15));
            cycle("random");
        end
        CmdValid = 1'b0;
        repeat (20) cycle("random_drain");

        // Asynchronous reset while both beams are broken
        CmdValid = 1'b1; CmdDir = 1'b1; CarCount = 4'd3;
        cycle("rst_accept");
        CmdValid = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 3 * H && !found; i++) begin
            cycle("rst_wait_ph2");
            found = ({Pin, Pout} == 2'b11);
        end
        check("rst_reached_ph2", found, 1'b1);
        #2;
        Reset = 1'b0;
        #1;
        check("async_reset_outs", {Pin, Pout, Busy, SeqDone, Reject}, 5'b0);
        t = -1; mrej = 1'b0;
        @(negedge Clk);
        Reset = 1'b1;
        #1;
        check("ready_after_mid_reset", CmdReady, 1'b1);
        dones = 0;
        for (int i = 0; i < 4 * H + 4; i++) begin
            cycle("post_reset_idle");
            dones += int'(SeqDone);
        end
        check("post_reset_no_seqdone", dones, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
